// File: rtl/alu_share_arbiter_if.sv
// Requester-side bundle for the shared ALU: request handshake plus response handshake.
// The arbiter takes the slave modport; each requester takes the master modport.
interface alu_share_arbiter_if #(
   parameter int unsigned WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_result;
   logic             resp_zero;
   logic             resp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_result, resp_zero, resp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_result, resp_zero, resp_err
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU_32 between two requesters, one operation in flight.
// Operands stay registered on the ALU until the next grant; results go back per port.
module alu_share_arbiter #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned ALU_LATENCY = 1
) (
   input  logic             clk,
   input  logic             reset,
   alu_share_arbiter_if.slave req0,
   alu_share_arbiter_if.slave req1,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] alu_left,
   output logic [WIDTH-1:0] alu_right,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             busy
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_ptr;
   logic             r_gnt;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_alu_op;
   logic [WIDTH-1:0] r_alu_left;
   logic [WIDTH-1:0] r_alu_right;
   logic [1:0]       r_rv;
   logic [1:0]       r_rz;
   logic [1:0]       r_re;
   logic [WIDTH-1:0] r_rres [2];

   logic             w_idle;
   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_hs;
   logic             w_sel;
   logic [3:0]       w_op;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic             w_legal;
   logic             w_resp_ack;

   // Grant: a lone requester wins, otherwise the pointer decides
   assign w_idle  = (r_state == S_IDLE);
   assign w_gnt0  = w_idle && req0.req_valid && (!req1.req_valid || !r_ptr);
   assign w_gnt1  = w_idle && req1.req_valid && (!req0.req_valid ||  r_ptr);
   assign w_hs    = w_gnt0 || w_gnt1;
   assign w_sel   = w_gnt1;
   assign w_op    = w_sel ? req1.req_op : req0.req_op;
   assign w_a     = w_sel ? req1.req_a  : req0.req_a;
   assign w_b     = w_sel ? req1.req_b  : req0.req_b;
   assign w_resp_ack = r_gnt ? req1.resp_ready : req0.resp_ready;

   always_comb begin
      w_legal = 1'b0;
      case (w_op)
         4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: w_legal = 1'b1;
         default:                             w_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_hs) w_next = w_legal ? S_EXEC : S_RESP;
         S_EXEC: if (r_cnt == '0) w_next = S_RESP;
         S_RESP: if (w_resp_ack) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Operand capture, latency countdown and per-port response registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr       <= 1'b0;
         r_gnt       <= 1'b0;
         r_cnt       <= '0;
         r_alu_op    <= '0;
         r_alu_left  <= '0;
         r_alu_right <= '0;
         r_rv        <= '0;
         r_rz        <= '0;
         r_re        <= '0;
         r_rres[0]   <= '0;
         r_rres[1]   <= '0;
      end else begin
         if (w_hs) begin
            r_ptr <= ~w_sel;
            r_gnt <= w_sel;
            if (w_legal) begin
               r_alu_op    <= w_op;
               r_alu_left  <= w_a;
               r_alu_right <= w_b;
               r_cnt       <= CNT_W'(ALU_LATENCY);
            end else begin
               r_rv[w_sel]   <= 1'b1;
               r_rres[w_sel] <= '0;
               r_rz[w_sel]   <= 1'b1;
               r_re[w_sel]   <= 1'b1;
            end
         end
         if (r_state == S_EXEC) begin
            if (r_cnt == '0) begin
               r_rv[r_gnt]   <= 1'b1;
               r_rres[r_gnt] <= alu_result;
               r_rz[r_gnt]   <= alu_zero;
               r_re[r_gnt]   <= 1'b0;
            end else begin
               r_cnt <= r_cnt - CNT_W'(1);
            end
         end
         if ((r_state == S_RESP) && w_resp_ack) begin
            r_rv[r_gnt]   <= 1'b0;
            r_rres[r_gnt] <= '0;
            r_rz[r_gnt]   <= 1'b0;
            r_re[r_gnt]   <= 1'b0;
         end
      end
   end

   assign req0.req_ready   = w_gnt0;
   assign req1.req_ready   = w_gnt1;
   assign req0.resp_valid  = r_rv[0];
   assign req0.resp_result = r_rres[0];
   assign req0.resp_zero   = r_rz[0];
   assign req0.resp_err    = r_re[0];
   assign req1.resp_valid  = r_rv[1];
   assign req1.resp_result = r_rres[1];
   assign req1.resp_zero   = r_rz[1];
   assign req1.resp_err    = r_re[1];
   assign alu_op    = r_alu_op;
   assign alu_left  = r_alu_left;
   assign alu_right = r_alu_right;
   assign busy      = !w_idle;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one DUT at default latency, one at latency 3,
// each paired with a behavioural ALU_32.
module tb_alu_share_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   int          n_total = 0;
   int          n_bad   = 0;

   logic [3:0]  alu_op,    alu_op3;
   logic [31:0] alu_left,  alu_left3;
   logic [31:0] alu_right, alu_right3;
   logic [31:0] alu_res,   alu_res3;
   logic        alu_z,     alu_z3;
   logic        busy,      busy3;

   alu_share_arbiter_if #(.WIDTH(32)) if0 ();
   alu_share_arbiter_if #(.WIDTH(32)) if1 ();
   alu_share_arbiter_if #(.WIDTH(32)) k0 ();
   alu_share_arbiter_if #(.WIDTH(32)) k1 ();

   alu_share_arbiter #(.WIDTH(32), .ALU_LATENCY(1)) u_dut (
      .clk(clk), .reset(reset), .req0(if0), .req1(if1),
      .alu_op(alu_op), .alu_left(alu_left), .alu_right(alu_right),
      .alu_result(alu_res), .alu_zero(alu_z), .busy(busy)
   );

   alu_share_arbiter #(.WIDTH(32), .ALU_LATENCY(3)) u_dut3 (
      .clk(clk), .reset(reset), .req0(k0), .req1(k1),
      .alu_op(alu_op3), .alu_left(alu_left3), .alu_right(alu_right3),
      .alu_result(alu_res3), .alu_zero(alu_z3), .busy(busy3)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd6:    return a - b;
         4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd12:   return ~(a | b);
         default: return 32'd0;
      endcase
   endfunction

   assign alu_res  = alu_f(alu_op, alu_left, alu_right);
   assign alu_z    = (alu_res == 32'd0);
   assign alu_res3 = alu_f(alu_op3, alu_left3, alu_right3);
   assign alu_z3   = (alu_res3 == 32'd0);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      if (p == 0) begin
         if0.req_valid = v; if0.req_op = op; if0.req_a = a; if0.req_b = b;
      end else begin
         if1.req_valid = v; if1.req_op = op; if1.req_a = a; if1.req_b = b;
      end
   endtask

   task automatic set_rr(input int p, input logic v);
      if (p == 0) if0.resp_ready = v;
      else        if1.resp_ready = v;
   endtask

   function automatic logic get_rv(input int p);
      return (p == 0) ? if0.resp_valid : if1.resp_valid;
   endfunction

   function automatic logic get_ready(input int p);
      return (p == 0) ? if0.req_ready : if1.req_ready;
   endfunction

   function automatic logic [31:0] get_res(input int p);
      return (p == 0) ? if0.resp_result : if1.resp_result;
   endfunction

   function automatic logic [1:0] get_ze(input int p);
      return (p == 0) ? {if0.resp_zero, if0.resp_err} : {if1.resp_zero, if1.resp_err};
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // Single-port transaction on the default-latency DUT with full timing check
   task automatic run_op(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez, input logic ee);
      int n;
      set_req(p, 1'b1, op, a, b);
      #1;
      chk("req_ready", 32'(get_ready(p)), 32'd1);
      step();
      set_req(p, 1'b0, 4'd0, 32'd0, 32'd0);
      if (!ee) begin
         chk("alu_op", 32'(alu_op), 32'(op));
         chk("alu_left", alu_left, a);
         chk("alu_right", alu_right, b);
      end
      n = 1;
      while (!get_rv(p) && n < 20) begin
         step();
         n++;
      end
      chk("resp_latency", n, ee ? 32'd1 : 32'd3);
      chk("resp_result", get_res(p), er);
      chk("resp_zero_err", 32'(get_ze(p)), 32'({ez, ee}));
      set_rr(p, 1'b1);
      step();
      set_rr(p, 1'b0);
      chk("resp_valid_clear", 32'(get_rv(p)), 32'd0);
      chk("busy_drop", 32'(busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int e;
      set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
      set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
      set_rr(0, 1'b0);
      set_rr(1, 1'b0);
      k0.req_valid = 1'b0; k0.req_op = 4'd0; k0.req_a = 32'd0; k0.req_b = 32'd0; k0.resp_ready = 1'b0;
      k1.req_valid = 1'b0; k1.req_op = 4'd0; k1.req_a = 32'd0; k1.req_b = 32'd0; k1.resp_ready = 1'b0;
      do_reset();

      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_alu_left", alu_left, 32'd0);
      chk("rst_alu_right", alu_right, 32'd0);
      chk("rst_resp0_valid", 32'(if0.resp_valid), 32'd0);
      chk("rst_resp1_valid", 32'(if1.resp_valid), 32'd0);
      chk("rst_resp0_result", if0.resp_result, 32'd0);
      chk("rst_ready0", 32'(if0.req_ready), 32'd0);

      run_op(0, 4'd2,  32'd3, 32'd5, 32'd8,          1'b0, 1'b0);
      run_op(0, 4'd6,  32'd3, 32'd5, 32'hFFFF_FFFE,  1'b0, 1'b0);
      run_op(0, 4'd7,  32'd3, 32'd5, 32'd1,          1'b0, 1'b0);
      run_op(0, 4'd12, 32'd3, 32'd5, 32'hFFFF_FFF8,  1'b0, 1'b0);
      run_op(0, 4'd6,  32'd5, 32'd5, 32'd0,          1'b1, 1'b0);

      // Illegal opcode must leave the ALU operands from the previous grant
      run_op(0, 4'd2,  32'd3, 32'd5, 32'd8,          1'b0, 1'b0);
      run_op(1, 4'd4,  32'd9, 32'd9, 32'd0,          1'b1, 1'b1);
      chk("illegal_keep_op", 32'(alu_op), 32'd2);
      chk("illegal_keep_left", alu_left, 32'd3);
      chk("illegal_keep_right", alu_right, 32'd5);

      // Contention with both requesters continuously valid
      do_reset();
      set_req(0, 1'b1, 4'd0, 32'd3, 32'd5);
      set_req(1, 1'b1, 4'd1, 32'd3, 32'd5);
      #1;
      for (int k = 0; k < 6; k++) begin
         e = k % 2;
         chk("rr_ready0", 32'(if0.req_ready), (e == 0) ? 32'd1 : 32'd0);
         chk("rr_ready1", 32'(if1.req_ready), (e == 1) ? 32'd1 : 32'd0);
         step();
         n = 1;
         while (!get_rv(e) && n < 20) begin
            chk("rr_other_quiet", 32'(get_rv(1 - e)), 32'd0);
            step();
            n++;
         end
         chk("rr_latency", n, 32'd3);
         chk("rr_other_quiet", 32'(get_rv(1 - e)), 32'd0);
         chk("rr_result", get_res(e), (e == 0) ? 32'd1 : 32'd7);
         set_rr(e, 1'b1);
         step();
         set_rr(e, 1'b0);
      end
      set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
      set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
      step();

      // Response backpressure on port 0 while port 1 waits
      set_req(0, 1'b1, 4'd2, 32'd3, 32'd5);
      #1;
      step();
      set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
      set_req(1, 1'b1, 4'd2, 32'd1, 32'd1);
      n = 1;
      while (!if0.resp_valid && n < 20) begin
         chk("bp_ready1_wait", 32'(if1.req_ready), 32'd0);
         step();
         n++;
      end
      chk("bp_latency", n, 32'd3);
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid_hold", 32'(if0.resp_valid), 32'd1);
         chk("bp_result_hold", if0.resp_result, 32'd8);
         chk("bp_ready1_hold", 32'(if1.req_ready), 32'd0);
         step();
      end
      set_rr(0, 1'b1);
      step();
      set_rr(0, 1'b0);
      chk("bp_resp0_clear", 32'(if0.resp_valid), 32'd0);
      chk("bp_resp0_result_clear", if0.resp_result, 32'd0);
      chk("bp_ready1_idle", 32'(if1.req_ready), 32'd1);
      step();
      set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
      n = 1;
      while (!if1.resp_valid && n < 20) begin
         step();
         n++;
      end
      chk("bp_p1_latency", n, 32'd3);
      chk("bp_p1_result", if1.resp_result, 32'd2);
      set_rr(1, 1'b1);
      step();
      set_rr(1, 1'b0);

      // Reset while EXEC: operation dropped, pointer back to port 0
      set_req(0, 1'b1, 4'd2, 32'd3, 32'd5);
      #1;
      step();
      set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
      chk("mid_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
      chk("mid_rst_alu_left", alu_left, 32'd0);
      chk("mid_rst_alu_right", alu_right, 32'd0);
      for (int c = 0; c < 3; c++) begin
         chk("mid_rst_no_resp0", 32'(if0.resp_valid), 32'd0);
         chk("mid_rst_no_resp1", 32'(if1.resp_valid), 32'd0);
         step();
      end
      set_req(0, 1'b1, 4'd0, 32'd3, 32'd5);
      set_req(1, 1'b1, 4'd1, 32'd3, 32'd5);
      #1;
      chk("mid_rst_ptr_ready0", 32'(if0.req_ready), 32'd1);
      chk("mid_rst_ptr_ready1", 32'(if1.req_ready), 32'd0);
      set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
      set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
      step();

      // Latency-3 instance: response five cycles after the handshake
      k0.req_valid = 1'b1; k0.req_op = 4'd2; k0.req_a = 32'd3; k0.req_b = 32'd5;
      #1;
      chk("lat3_ready", 32'(k0.req_ready), 32'd1);
      step();
      k0.req_valid = 1'b0;
      n = 1;
      while (!k0.resp_valid && n < 20) begin
         step();
         n++;
      end
      chk("lat3_latency", n, 32'd5);
      chk("lat3_result", k0.resp_result, 32'd8);
      chk("lat3_zero_err", 32'({k0.resp_zero, k0.resp_err}), 32'd0);
      k0.resp_ready = 1'b1;
      step();
      k0.resp_ready = 1'b0;
      chk("lat3_busy_drop", 32'(busy3), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
